icache_sa: RTL and testbench

Parametrised N-way set-associative instruction cache; the successor to the direct-mapped instruction cache. It sits between the fetch stage and the instruction memory port. It returns a 32-bit instruction per request, refills whole blocks word-by-word over the `ifetch`/`iready` interface, and selects victims by per-set LRU. It adds request/valid handshaking, global flush and hit/miss statistics counters.

---
 rtl/icache_pkg.sv | 36 +++
 rtl/icache_lru.sv | 72 +++++++
 rtl/icache_sa.sv | 189 ++++++++++++++++++
 tb/tb_icache_sa.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_pkg
// Brief   : Shared types and field-width helpers for the set-associative icache.
// Revision: 1.0
// ============================================================================
package icache_pkg;

    localparam int C_INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_REFILL  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

    function automatic int offset_width(input int words);
        return $clog2(words);
    endfunction

    // Zero-width fields are kept at one bit so single-set/single-way builds still elaborate
    function automatic int index_width(input int sets);
        return (sets > 1) ? $clog2(sets) : 1;
    endfunction

    function automatic int tag_width(input int words, input int sets);
        return 32 - 2 - $clog2(words) - $clog2(sets);
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_lru.sv
`default_nettype none
// ============================================================================
// Module  : icache_lru
// Brief   : Per-set way ages, MRU update and victim selection.
// Revision: 1.0
// ============================================================================
module icache_lru
    import icache_pkg::*;
#(
    parameter int WAYS = 2,
    parameter int SETS = 32
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic [index_width(SETS)-1:0] set_idx,
    input  logic [WAYS-1:0]              valid,
    input  logic                         touch,
    input  logic                         fill,
    input  logic [way_width(WAYS)-1:0]   touch_way,
    output logic [way_width(WAYS)-1:0]   victim
);
    localparam int C_WAYW = way_width(WAYS);

    logic [C_WAYW-1:0] r_age [SETS][WAYS];
    logic [C_WAYW-1:0] w_old;
    logic [C_WAYW-1:0] w_best;
    logic              w_found;

    // A fill replaces the line, so its previous age is treated as the oldest;
    // this turns all-zero reset ages into a proper ordering as the set fills.
    assign w_old = fill ? C_WAYW'(WAYS - 1) : r_age[set_idx][touch_way];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= '0;
        end else if (clear) begin
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    r_age[s][w] <= '0;
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (C_WAYW'(w) == touch_way)
                    r_age[set_idx][w] <= '0;
                else if (r_age[set_idx][w] < w_old)
                    r_age[set_idx][w] <= r_age[set_idx][w] + 1'b1;
            end
        end
    end

    always_comb begin
        w_found = 1'b0;
        w_best  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_found && !valid[w]) begin
                w_best  = C_WAYW'(w);
                w_found = 1'b1;
            end
        end
        if (!w_found) begin
            for (int w = 1; w < WAYS; w++) begin
                if (r_age[set_idx][w] > r_age[set_idx][w_best])
                    w_best = C_WAYW'(w);
            end
        end
        victim = w_best;
    end

endmodule
`default_nettype wire

// File: rtl/icache_sa.sv
`default_nettype none
// ============================================================================
// Module  : icache_sa
// Brief   : N-way set-associative instruction cache with LRU and block refill.
// Revision: 1.0
// ============================================================================
module icache_sa
    import icache_pkg::*;
#(
    parameter int CACHESIZE     = 1024,
    parameter int WORDSPERBLOCK = 4,
    parameter int WAYS          = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ireq,
    input  logic [31:0]          instraddress,
    input  logic                 flush,
    input  logic [C_INSTR_W-1:0] ifetch,
    input  logic                 iready,
    output logic [C_INSTR_W-1:0] instruction,
    output logic                 ivalid,
    output logic                 hit,
    output logic                 miss,
    output logic                 busy,
    output logic                 fetchreq,
    output logic [31:0]          fetchaddr,
    output logic [31:0]          hitcount,
    output logic [31:0]          misscount
);
    localparam int C_SETS = CACHESIZE / (4 * WORDSPERBLOCK * WAYS);
    localparam int C_OFFW = offset_width(WORDSPERBLOCK);
    localparam int C_IDXW = index_width(C_SETS);
    localparam int C_TAGW = tag_width(WORDSPERBLOCK, C_SETS);
    localparam int C_WAYW = way_width(WAYS);
    localparam logic [C_OFFW-1:0] C_LAST = C_OFFW'(WORDSPERBLOCK - 1);

    state_t                r_state;
    logic [31:2]           r_addr;
    logic [C_WAYW-1:0]     r_hit_way;
    logic [C_WAYW-1:0]     r_victim;
    logic [C_OFFW-1:0]     r_wcnt;
    logic                  r_flush_pend;
    logic [WAYS-1:0]       r_valid [C_SETS];
    logic [C_TAGW-1:0]     r_tag   [WAYS][C_SETS];
    logic [C_INSTR_W-1:0]  r_data  [WAYS][C_SETS][WORDSPERBLOCK];

    logic [C_IDXW-1:0]     w_in_set, w_set;
    logic [C_TAGW-1:0]     w_in_tag, w_tag;
    logic [C_OFFW-1:0]     w_in_word, w_word;
    logic                  w_lk_hit;
    logic [C_WAYW-1:0]     w_lk_way, w_victim, w_touch_way;
    logic [C_INSTR_W-1:0]  w_lk_data;
    logic                  w_flush_exec, w_fill, w_touch;
    logic                  w_unused;

    assign w_in_set  = (C_SETS > 1) ? instraddress[2+C_OFFW +: C_IDXW] : '0;
    assign w_in_tag  = instraddress[31 -: C_TAGW];
    assign w_in_word = instraddress[2 +: C_OFFW];
    assign w_set     = (C_SETS > 1) ? r_addr[2+C_OFFW +: C_IDXW] : '0;
    assign w_tag     = r_addr[31 -: C_TAGW];
    assign w_word    = r_addr[2 +: C_OFFW];
    assign w_unused  = ^instraddress[1:0];

    // Tag match is resolved on the incoming address so hit/ivalid can be registered into LOOKUP
    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_in_set][w] && (r_tag[w][w_in_set] == w_in_tag)) begin
                w_lk_hit = 1'b1;
                w_lk_way = C_WAYW'(w);
            end
        end
    end
    assign w_lk_data = r_data[w_lk_way][w_in_set][w_in_word];

    assign w_flush_exec = (r_state == ST_IDLE) && (flush || r_flush_pend);
    assign w_fill       = (r_state == ST_REFILL) && iready && (r_wcnt == C_LAST);
    assign w_touch      = ((r_state == ST_LOOKUP) && hit) || w_fill;
    assign w_touch_way  = w_fill ? r_victim : r_hit_way;

    icache_lru #(
        .WAYS (WAYS),
        .SETS (C_SETS)
    ) u_lru (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (w_flush_exec),
        .set_idx   (w_set),
        .valid     (r_valid[w_set]),
        .touch     (w_touch),
        .fill      (w_fill),
        .touch_way (w_touch_way),
        .victim    (w_victim)
    );

    always_ff @(posedge clk) begin
        if (r_state == ST_REFILL && iready) begin
            r_data[r_victim][w_set][r_wcnt] <= ifetch;
            if (r_wcnt == C_LAST)
                r_tag[r_victim][w_set] <= w_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_hit_way    <= '0;
            r_victim     <= '0;
            r_wcnt       <= '0;
            r_flush_pend <= 1'b0;
            for (int s = 0; s < C_SETS; s++)
                r_valid[s] <= '0;
            instruction  <= '0;
            ivalid       <= 1'b0;
            hit          <= 1'b0;
            miss         <= 1'b0;
            busy         <= 1'b0;
            fetchreq     <= 1'b0;
            fetchaddr    <= '0;
            hitcount     <= '0;
            misscount    <= '0;
        end else begin
            hit    <= 1'b0;
            miss   <= 1'b0;
            ivalid <= 1'b0;
            if (flush && r_state != ST_IDLE)
                r_flush_pend <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_flush_exec) begin
                        for (int s = 0; s < C_SETS; s++)
                            r_valid[s] <= '0;
                        r_flush_pend <= 1'b0;
                    end else if (ireq) begin
                        r_addr    <= instraddress[31:2];
                        r_hit_way <= w_lk_way;
                        hit       <= w_lk_hit;
                        miss      <= !w_lk_hit;
                        ivalid    <= w_lk_hit;
                        if (w_lk_hit)
                            instruction <= w_lk_data;
                        busy      <= 1'b1;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (hit) begin
                        if (~&hitcount)
                            hitcount <= hitcount + 32'd1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (~&misscount)
                            misscount <= misscount + 32'd1;
                        r_victim  <= w_victim;
                        r_wcnt    <= '0;
                        fetchreq  <= 1'b1;
                        fetchaddr <= {r_addr[31:2+C_OFFW], {(2+C_OFFW){1'b0}}};
                        r_state   <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (iready) begin
                        r_wcnt    <= r_wcnt + 1'b1;
                        fetchaddr <= fetchaddr + 32'd4;
                        if (r_wcnt == w_word)
                            instruction <= ifetch;
                        if (r_wcnt == C_LAST) begin
                            r_valid[w_set][r_victim] <= 1'b1;
                            fetchreq <= 1'b0;
                            ivalid   <= 1'b1;
                            r_state  <= ST_RESPOND;
                        end
                    end
                end
                ST_RESPOND: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_sa.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_sa
// Brief   : Scoreboard bench for icache_sa (2-way build plus a direct-mapped build).
// Revision: 1.0
// ============================================================================
module tb_icache_sa;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ireq = 1'b0, flush = 1'b0, iready = 1'b0;
    logic [31:0] instraddress = '0, ifetch = '0;
    logic [31:0] instruction, fetchaddr, hitcount, misscount;
    logic        ivalid, hit, miss, busy, fetchreq;

    logic        ireq1 = 1'b0, iready1 = 1'b0;
    logic [31:0] instraddress1 = '0, ifetch1 = '0;
    logic [31:0] instruction1, fetchaddr1, hitcount1, misscount1;
    logic        ivalid1, hit1, miss1, busy1, fetchreq1;

    icache_sa #(.CACHESIZE(1024), .WORDSPERBLOCK(4), .WAYS(2)) dut (
        .clk(clk), .reset_n(reset_n), .ireq(ireq), .instraddress(instraddress),
        .flush(flush), .ifetch(ifetch), .iready(iready), .instruction(instruction),
        .ivalid(ivalid), .hit(hit), .miss(miss), .busy(busy), .fetchreq(fetchreq),
        .fetchaddr(fetchaddr), .hitcount(hitcount), .misscount(misscount)
    );

    icache_sa #(.CACHESIZE(1024), .WORDSPERBLOCK(4), .WAYS(1)) dut_dm (
        .clk(clk), .reset_n(reset_n), .ireq(ireq1), .instraddress(instraddress1),
        .flush(1'b0), .ifetch(ifetch1), .iready(iready1), .instruction(instruction1),
        .ivalid(ivalid1), .hit(hit1), .miss(miss1), .busy(busy1), .fetchreq(fetchreq1),
        .fetchaddr(fetchaddr1), .hitcount(hitcount1), .misscount(misscount1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] base;
        base = {a[31:4], 4'h0};
        return 32'hAA000000 | (base << 4) | {30'b0, a[3:2]};
    endfunction

    typedef struct {
        logic        exp_hit;
        logic [31:0] exp_instr;
    } exp_t;
    exp_t sb[$];

    // Output monitor: lookup outcome and returned word against the scoreboard
    initial forever begin
        @(negedge clk);
        if (hit || miss) begin
            if (sb.size() == 0) chk("unexpected_lookup", {30'b0, hit, miss}, 32'd0);
            else chk("lookup_kind", {30'b0, hit, miss}, sb[0].exp_hit ? 32'd2 : 32'd1);
        end
        if (ivalid) begin
            chk("ivalid_excl_miss", {31'b0, miss}, 32'd0);
            if (sb.size() == 0) chk("unexpected_ivalid", instruction, 32'hDEADDEAD);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("instruction", instruction, e.exp_instr);
            end
        end
    end

    // Memory responder with random gaps; checks each beat's fetch address
    logic [31:0] exp_base = '0;
    int          beats = 0, blk_beats = 0, beat_limit = 1000;
    bit          force_ready = 1'b0;
    initial forever begin
        @(posedge clk); #2;
        if (!fetchreq) blk_beats = 0;
        if (fetchreq && beats < beat_limit && $urandom_range(0, 3) != 0) begin
            chk("fetchaddr", fetchaddr, exp_base + 32'(4 * blk_beats));
            ifetch = mem_word(fetchaddr);
            iready = 1'b1;
            beats++;
            blk_beats++;
        end else begin
            iready = force_ready;
            ifetch = $urandom();
        end
    end

    initial forever begin
        @(posedge clk); #2;
        iready1 = fetchreq1;
        ifetch1 = mem_word(fetchaddr1);
    end

    int n_accept = 0;

    task automatic access(input logic [31:0] a, input logic exp_hit, input bit hold);
        int t;
        sb.push_back('{exp_hit, mem_word(a)});
        exp_base = {a[31:4], 4'h0};
        @(negedge clk);
        instraddress = a;
        ireq = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!busy && t < 8);
        if (!hold) ireq = 1'b0;
        chk("accepted", {31'b0, busy}, 32'd1);
        if (busy) n_accept++;
        chk("lookup_pulse", {30'b0, hit, miss}, exp_hit ? 32'd2 : 32'd1);
        t = 0;
        while (!ivalid && t < 64) begin @(posedge clk); #1; t++; end
        chk("ivalid_seen", {31'b0, ivalid}, 32'd1);
        if (exp_hit) chk("hit_latency", 32'(t), 32'd0);
        @(posedge clk); #1;
        ireq = 1'b0;
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    task automatic access_dm(input logic [31:0] a);
        int t;
        @(negedge clk);
        instraddress1 = a;
        ireq1 = 1'b1;
        @(posedge clk); #1;
        ireq1 = 1'b0;
        chk("dm_miss", {31'b0, miss1}, 32'd1);
        t = 0;
        while (!ivalid1 && t < 64) begin @(posedge clk); #1; t++; end
        chk("dm_instr", instruction1, mem_word(a));
        @(posedge clk); #1;
    endtask

    logic [31:0] h0, m0;
    int          a0;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_flags", {27'b0, hit, miss, ivalid, busy, fetchreq}, 32'd0);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_fetchaddr", fetchaddr, 32'd0);
        chk("rst_counts", hitcount | misscount, 32'd0);
        reset_n = 1'b1;

        access(32'h010, 1'b0, 1'b0);
        access(32'h018, 1'b1, 1'b0);

        access(32'h000, 1'b0, 1'b0);
        access(32'h200, 1'b0, 1'b0);
        access(32'h000, 1'b1, 1'b0);
        access(32'h400, 1'b0, 1'b0);
        access(32'h000, 1'b1, 1'b0);
        access(32'h200, 1'b0, 1'b0);

        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        access(32'h000, 1'b0, 1'b0);

        fork
            access(32'h040, 1'b0, 1'b0);
            begin
                repeat (4) @(negedge clk);
                chk("flush_while_busy", {31'b0, busy}, 32'd1);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
            end
        join
        access(32'h040, 1'b0, 1'b0);

        @(negedge clk);
        instraddress = 32'h040; flush = 1'b1; ireq = 1'b1;
        @(posedge clk); #1;
        chk("flush_beats_ireq", {31'b0, busy}, 32'd0);
        @(negedge clk);
        flush = 1'b0; ireq = 1'b0;
        access(32'h040, 1'b0, 1'b0);

        access(32'h050, 1'b0, 1'b0);
        force_ready = 1'b1;
        repeat (5) @(negedge clk);
        force_ready = 1'b0;
        access(32'h050, 1'b1, 1'b0);

        m0 = misscount;
        access(32'h060, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("no_extra_accept", {31'b0, busy}, 32'd0);
        chk("hold_misscount", misscount - m0, 32'd1);

        sb.push_back('{1'b0, mem_word(32'h030)});
        exp_base = 32'h030;
        beats = 0; beat_limit = 2;
        @(negedge clk); instraddress = 32'h030; ireq = 1'b1;
        @(posedge clk); #1; ireq = 1'b0;
        for (int i = 0; i < 64 && beats < 2; i++) @(posedge clk);
        @(posedge clk); #1;
        chk("two_beats_taken", 32'(beats), 32'd2);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("rst_mid_flags", {27'b0, hit, miss, ivalid, busy, fetchreq}, 32'd0);
        chk("rst_mid_fetchaddr", fetchaddr, 32'd0);
        chk("rst_mid_counts", hitcount | misscount, 32'd0);
        beat_limit = 1000;
        @(negedge clk); reset_n = 1'b1;
        access(32'h030, 1'b0, 1'b0);

        h0 = hitcount; m0 = misscount; a0 = n_accept;
        access(32'h070, 1'b0, 1'b0);
        access(32'h074, 1'b1, 1'b0);
        access(32'h078, 1'b1, 1'b0);
        access(32'h270, 1'b0, 1'b0);
        access(32'h070, 1'b1, 1'b0);
        access(32'h470, 1'b0, 1'b0);
        access(32'h270, 1'b0, 1'b0);
        access(32'h470, 1'b1, 1'b0);
        access(32'h07C, 1'b0, 1'b0);
        access(32'h47C, 1'b1, 1'b0);
        chk("run_hits", hitcount - h0, 32'd5);
        chk("run_misses", misscount - m0, 32'd5);
        chk("run_total", (hitcount - h0) + (misscount - m0), 32'(n_accept - a0));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        h0 = hitcount1; m0 = misscount1;
        access_dm(32'h000);
        access_dm(32'h400);
        access_dm(32'h000);
        chk("dm_misscount", misscount1 - m0, 32'd3);
        chk("dm_hitcount", hitcount1 - h0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
